// File: rtl/jpeg_mcu_block_scheduler_pkg.sv
`default_nettype none
// ============================================================================
// Module  : jpeg_sched_pkg
// Brief   : Shared types and constants for the JPEG MCU block scheduler.
// Revision: 1.0  initial release
// ============================================================================
package jpeg_sched_pkg;

    localparam int BLK_COEFS    = 64;
    localparam int BLKS_PER_MCU = 6;

    // Component encodings carried on blk_comp
    localparam logic [1:0] COMP_Y  = 2'd0;
    localparam logic [1:0] COMP_CB = 2'd1;
    localparam logic [1:0] COMP_CR = 2'd2;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_DRAIN = 3'd2,
        ST_RMARK = 3'd3,
        ST_DONE  = 3'd4
    } sched_state_e;

    // 4:2:0 MCU layout: blocks 0..3 luma, 4 Cb, 5 Cr
    function automatic logic [1:0] comp_of_idx(input logic [2:0] idx);
        if (idx < 3'd4)
            return COMP_Y;
        else if (idx == 3'd4)
            return COMP_CB;
        else
            return COMP_CR;
    endfunction

endpackage
`default_nettype wire

// File: rtl/jpeg_mcu_block_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module  : jpeg_mcu_block_scheduler_if
// Brief   : Block request / coefficient return link between the scheduler
//           (master) and the DCT/quantise/entropy datapath (slave).
// Revision: 1.0  initial release
// ============================================================================
interface jpeg_mcu_block_scheduler_if;
    logic       blk_valid;
    logic       blk_ready;
    logic [1:0] blk_comp;
    logic [2:0] blk_idx;
    logic       coef_valid;

    modport master (
        output blk_valid, blk_comp, blk_idx,
        input  blk_ready, coef_valid
    );

    modport slave (
        input  blk_valid, blk_comp, blk_idx,
        output blk_ready, coef_valid
    );
endinterface
`default_nettype wire

// File: rtl/jpeg_mcu_block_scheduler_drain.sv
`default_nettype none
// ============================================================================
// Module  : jpeg_coef_drain_counter
// Brief   : Counts returned coefficients of one block; tc_o flags the beat
//           that completes the block. The counter self-clears on that beat.
// Revision: 1.0  initial release
// ============================================================================
module jpeg_coef_drain_counter #(
    parameter int BLK_COEFS = 64
) (
    input  wire logic clk,
    input  wire logic rst_n,
    input  wire logic clr_i,
    input  wire logic inc_i,
    output logic      tc_o
);
    localparam int CW = $clog2(BLK_COEFS + 1);

    logic [CW-1:0] cnt_q;

    assign tc_o = inc_i && (cnt_q == CW'(BLK_COEFS - 1));

    // Coefficient count; clear has priority over increment
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt_q <= '0;
        else if (clr_i || tc_o)
            cnt_q <= '0;
        else if (inc_i)
            cnt_q <= cnt_q + 1'b1;
    end
endmodule
`default_nettype wire

// File: rtl/jpeg_mcu_block_scheduler.sv
`default_nettype none
// ============================================================================
// Module  : jpeg_mcu_block_scheduler
// Brief   : Sequences Y0..Y3,Cb,Cr blocks of each 4:2:0 MCU into the shared
//           coefficient datapath, inserting restart markers and DC predictor
//           clears every restart interval.
// Revision: 1.0  initial release
// ============================================================================
module jpeg_mcu_block_scheduler #(
    parameter int BLK_COEFS    = 64,
    parameter int MCU_W        = 16,
    parameter int BLKS_PER_MCU = 6
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    input  wire logic             start_i,
    input  wire logic             abort_i,
    input  wire logic [MCU_W-1:0] num_mcu_i,
    input  wire logic [MCU_W-1:0] restart_interval_i,
    jpeg_mcu_block_scheduler_if.master dp,
    output logic                  dc_pred_clr_o,
    output logic                  rst_marker_o,
    output logic [2:0]            rst_num_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  err_o
);
    import jpeg_sched_pkg::*;

    localparam logic [2:0] LAST_IDX = 3'(BLKS_PER_MCU - 1);

    sched_state_e     state_q, state_d;
    logic [2:0]       blk_cnt_q, blk_cnt_d;
    logic [MCU_W-1:0] mcu_cnt_q, mcu_cnt_d;
    logic [MCU_W-1:0] int_cnt_q, int_cnt_d;
    logic [MCU_W-1:0] num_mcu_q, num_mcu_d;
    logic [MCU_W-1:0] rint_q, rint_d;
    logic [2:0]       rst_num_q, rst_num_d;
    logic             blk_valid_q, blk_valid_d;
    logic [1:0]       blk_comp_q, blk_comp_d;
    logic [2:0]       blk_idx_q, blk_idx_d;
    logic             dc_clr_q, dc_clr_d;
    logic             marker_q, marker_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             err_q, err_d;

    logic             w_start_acc;
    logic             w_hs;
    logic             w_coef_inc;
    logic             w_tc;
    logic [MCU_W-1:0] w_mcu_inc;
    logic [MCU_W-1:0] w_int_inc;

    assign w_start_acc = start_i && !abort_i && (state_q == ST_IDLE);
    assign w_hs        = (state_q == ST_ISSUE) && blk_valid_q && dp.blk_ready;
    assign w_coef_inc  = (state_q == ST_DRAIN) && dp.coef_valid;
    assign w_mcu_inc   = mcu_cnt_q + MCU_W'(1);
    assign w_int_inc   = int_cnt_q + MCU_W'(1);

    jpeg_coef_drain_counter #(
        .BLK_COEFS (BLK_COEFS)
    ) u_drain (
        .clk   (clk),
        .rst_n (rst_n),
        .clr_i (abort_i || w_hs),
        .inc_i (w_coef_inc),
        .tc_o  (w_tc)
    );

    // State, counters and all registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            blk_cnt_q   <= '0;
            mcu_cnt_q   <= '0;
            int_cnt_q   <= '0;
            num_mcu_q   <= '0;
            rint_q      <= '0;
            rst_num_q   <= '0;
            blk_valid_q <= 1'b0;
            blk_comp_q  <= '0;
            blk_idx_q   <= '0;
            dc_clr_q    <= 1'b0;
            marker_q    <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            blk_cnt_q   <= blk_cnt_d;
            mcu_cnt_q   <= mcu_cnt_d;
            int_cnt_q   <= int_cnt_d;
            num_mcu_q   <= num_mcu_d;
            rint_q      <= rint_d;
            rst_num_q   <= rst_num_d;
            blk_valid_q <= blk_valid_d;
            blk_comp_q  <= blk_comp_d;
            blk_idx_q   <= blk_idx_d;
            dc_clr_q    <= dc_clr_d;
            marker_q    <= marker_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    // Next state and frame/interval/block counters
    always_comb begin
        state_d   = state_q;
        blk_cnt_d = blk_cnt_q;
        mcu_cnt_d = mcu_cnt_q;
        int_cnt_d = int_cnt_q;
        num_mcu_d = num_mcu_q;
        rint_d    = rint_q;
        rst_num_d = rst_num_q;
        if (abort_i) begin
            state_d   = ST_IDLE;
            blk_cnt_d = '0;
            mcu_cnt_d = '0;
            int_cnt_d = '0;
            rst_num_d = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (w_start_acc) begin
                        num_mcu_d = num_mcu_i;
                        rint_d    = restart_interval_i;
                        rst_num_d = '0;
                        blk_cnt_d = '0;
                        mcu_cnt_d = '0;
                        int_cnt_d = '0;
                        state_d   = (num_mcu_i == '0) ? ST_DONE : ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (w_hs)
                        state_d = ST_DRAIN;
                end
                ST_DRAIN: begin
                    if (w_tc) begin
                        if (blk_cnt_q != LAST_IDX) begin
                            blk_cnt_d = blk_cnt_q + 3'd1;
                            state_d   = ST_ISSUE;
                        end else begin
                            blk_cnt_d = '0;
                            mcu_cnt_d = w_mcu_inc;
                            int_cnt_d = w_int_inc;
                            if (w_mcu_inc == num_mcu_q)
                                state_d = ST_DONE;
                            else if ((rint_q != '0) && (w_int_inc == rint_q))
                                state_d = ST_RMARK;
                            else
                                state_d = ST_ISSUE;
                        end
                    end
                end
                ST_RMARK: begin
                    rst_num_d = rst_num_q + 3'd1;
                    int_cnt_d = '0;
                    state_d   = ST_ISSUE;
                end
                ST_DONE: begin
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // Registered output values derived from the upcoming state
    always_comb begin
        blk_valid_d = (state_d == ST_ISSUE);
        blk_idx_d   = blk_cnt_d;
        blk_comp_d  = comp_of_idx(blk_cnt_d);
        dc_clr_d    = w_start_acc || (state_d == ST_RMARK);
        marker_d    = (state_d == ST_RMARK);
        done_d      = (state_q == ST_DONE) && !abort_i;
        busy_d      = busy_q;
        if (abort_i || (state_q == ST_DONE))
            busy_d = 1'b0;
        else if (w_start_acc)
            busy_d = 1'b1;
        err_d = err_q;
        if (dp.coef_valid && (state_q != ST_DRAIN))
            err_d = 1'b1;
        if (w_start_acc)
            err_d = 1'b0;
    end

    assign dp.blk_valid  = blk_valid_q;
    assign dp.blk_comp   = blk_comp_q;
    assign dp.blk_idx    = blk_idx_q;
    assign dc_pred_clr_o = dc_clr_q;
    assign rst_marker_o  = marker_q;
    assign rst_num_o     = rst_num_q;
    assign busy_o        = busy_q;
    assign done_o        = done_q;
    assign err_o         = err_q;
endmodule
`default_nettype wire

// File: tb/tb_jpeg_mcu_block_scheduler.sv
`default_nettype none
// ============================================================================
// Module  : tb_jpeg_mcu_block_scheduler
// Brief   : Scoreboard bench for the JPEG MCU block scheduler.
// Revision: 1.0  initial release
// ============================================================================
module tb_jpeg_mcu_block_scheduler;
    localparam int K_REQ   = 0;
    localparam int K_MARK  = 1;
    localparam int K_DCCLR = 2;
    localparam int K_DONE  = 3;

    typedef struct {
        int kind;
        int val;
    } ev_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [15:0] num_mcu = '0;
    logic [15:0] rint = '0;
    logic        dc_pred_clr, rst_marker, busy, done, err;
    logic [2:0]  rst_num;

    jpeg_mcu_block_scheduler_if dp_if ();

    jpeg_mcu_block_scheduler #(
        .BLK_COEFS    (64),
        .MCU_W        (16),
        .BLKS_PER_MCU (6)
    ) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .start_i            (start),
        .abort_i            (abort),
        .num_mcu_i          (num_mcu),
        .restart_interval_i (rint),
        .dp                 (dp_if),
        .dc_pred_clr_o      (dc_pred_clr),
        .rst_marker_o       (rst_marker),
        .rst_num_o          (rst_num),
        .busy_o             (busy),
        .done_o             (done),
        .err_o              (err)
    );

    always #5 clk = ~clk;

    ev_t exp_q[$];
    int  checks = 0;
    int  errors = 0;
    int  n_mark = 0;
    int  n_dcclr = 0;
    int  comp_tab[6] = '{0, 0, 0, 0, 1, 2};

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic sb_pop(input int kind, input int val);
        ev_t e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL sb_unexpected: got kind %0d val %0d, expected nothing", kind, val);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != kind || e.val != val) begin
                errors++;
                $display("FAIL sb_event: got kind %0d val %0d expected kind %0d val %0d",
                         kind, val, e.kind, e.val);
            end
        end
    endtask

    function automatic void push(input int kind, input int val);
        ev_t e;
        e.kind = kind;
        e.val  = val;
        exp_q.push_back(e);
    endfunction

    // Expected event stream of a full frame
    function automatic void expect_frame(input int num, input int ri);
        int rn = 0;
        push(K_DCCLR, 0);
        for (int m = 1; m <= num; m++) begin
            for (int b = 0; b < 6; b++) push(K_REQ, comp_tab[b] * 8 + b);
            if (m != num && ri != 0 && (m % ri) == 0) begin
                push(K_MARK, rn);
                push(K_DCCLR, 0);
                rn = (rn + 1) % 8;
            end
        end
        push(K_DONE, 0);
    endfunction

    // Monitor: compares every DUT event against the scoreboard
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (rst_marker) begin
                    n_mark++;
                    sb_pop(K_MARK, int'(rst_num));
                end
                if (dc_pred_clr) begin
                    n_dcclr++;
                    sb_pop(K_DCCLR, 0);
                end
                if (dp_if.blk_valid && dp_if.blk_ready)
                    sb_pop(K_REQ, int'(dp_if.blk_comp) * 8 + int'(dp_if.blk_idx));
                if (done)
                    sb_pop(K_DONE, 0);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(output bit ok);
        int t = 0;
        while (!dp_if.blk_valid && t < 200) begin
            tick();
            t++;
        end
        ok = dp_if.blk_valid;
        if (!ok) chk("wait_blk_valid_timeout", 0, 1);
    endtask

    // Accept one request (blk_ready already 1) and return 64 coefficients
    task automatic serve_block(input bit pulse_start);
        bit ok;
        wait_valid(ok);
        if (ok) begin
            tick();
            dp_if.coef_valid = 1'b1;
            for (int k = 1; k <= 64; k++) begin
                start = pulse_start && (k == 5);
                tick();
                if (k == 63) chk("drain_no_early_req", int'(dp_if.blk_valid), 0);
            end
            dp_if.coef_valid = 1'b0;
            start = 1'b0;
        end
    endtask

    task automatic wait_done();
        int t = 0;
        while (!done && t < 50) begin
            tick();
            t++;
        end
        chk("done_seen", int'(done), 1);
        tick();
        chk("busy_after_done", int'(busy), 0);
        chk("sb_empty", exp_q.size(), 0);
    endtask

    task automatic run_frame(input int num, input int ri, input int pulse_blk);
        num_mcu = 16'(num);
        rint    = 16'(ri);
        dp_if.blk_ready = 1'b1;
        expect_frame(num, ri);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("busy_after_start", int'(busy), 1);
        for (int b = 0; b < num * 6; b++) serve_block(b == pulse_blk);
        wait_done();
    endtask

    initial begin
        int m0, d0;
        dp_if.blk_ready  = 1'b0;
        dp_if.coef_valid = 1'b0;
        repeat (3) tick();
        chk("reset_outs", int'({dp_if.blk_valid, dp_if.blk_comp, dp_if.blk_idx, dc_pred_clr,
                                rst_marker, rst_num, busy, done, err}), 0);
        rst_n = 1'b1;
        tick();
        chk("post_reset_outs", int'({dp_if.blk_valid, busy, done, err}), 0);

        // Single MCU, no restart markers
        m0 = n_mark; d0 = n_dcclr;
        run_frame(1, 0, -1);
        chk("t1_markers", n_mark - m0, 0);
        chk("t1_dcclr", n_dcclr - d0, 1);
        chk("t1_err", int'(err), 0);

        // Five MCUs, interval 2; a stray start mid-frame is ignored
        m0 = n_mark; d0 = n_dcclr;
        run_frame(5, 2, 8);
        chk("t2_markers", n_mark - m0, 2);
        chk("t2_dcclr", n_dcclr - d0, 3);

        // Twenty MCUs, interval 1; marker number wraps at 8
        m0 = n_mark; d0 = n_dcclr;
        run_frame(20, 1, -1);
        chk("t3_markers", n_mark - m0, 19);
        chk("t3_dcclr", n_dcclr - d0, 20);

        // Back-pressure: request held stable, stray coef_valid flagged
        num_mcu = 16'd1;
        rint    = 16'd0;
        dp_if.blk_ready = 1'b0;
        expect_frame(1, 0);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 0; c < 10; c++) begin
            chk("stall_valid", int'(dp_if.blk_valid), 1);
            chk("stall_req", int'(dp_if.blk_comp) * 8 + int'(dp_if.blk_idx), 0);
            dp_if.coef_valid = (c == 3);
            tick();
        end
        dp_if.coef_valid = 1'b0;
        chk("stall_err", int'(err), 1);
        dp_if.blk_ready = 1'b1;
        for (int b = 0; b < 6; b++) serve_block(1'b0);
        wait_done();

        // Abort mid-drain after 30 coefficients; err survives abort
        num_mcu = 16'd2;
        dp_if.blk_ready = 1'b0;
        push(K_DCCLR, 0);
        push(K_REQ, 0);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("start_clears_err", int'(err), 0);
        dp_if.coef_valid = 1'b1;
        tick();
        dp_if.coef_valid = 1'b0;
        chk("issue_coef_err", int'(err), 1);
        dp_if.blk_ready = 1'b1;
        tick();
        dp_if.coef_valid = 1'b1;
        repeat (30) tick();
        dp_if.coef_valid = 1'b0;
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_busy", int'(busy), 0);
        chk("abort_valid", int'(dp_if.blk_valid), 0);
        chk("abort_err_kept", int'(err), 1);
        for (int c = 0; c < 5; c++) begin
            chk("abort_no_done", int'(done), 0);
            tick();
        end
        chk("abort_sb_empty", exp_q.size(), 0);
        run_frame(1, 0, -1);
        chk("restart_err_clear", int'(err), 0);

        // Empty frame: done two cycles after start, no request
        num_mcu = 16'd0;
        push(K_DCCLR, 0);
        push(K_DONE, 0);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("zero_c1", int'({done, busy, dp_if.blk_valid}), 3'b010);
        tick();
        chk("zero_c2", int'({done, busy, dp_if.blk_valid}), 3'b100);
        tick();
        chk("zero_c3_done", int'(done), 0);
        chk("zero_sb_empty", exp_q.size(), 0);

        // Asynchronous reset in the middle of a drain
        num_mcu = 16'd1;
        push(K_DCCLR, 0);
        push(K_REQ, 0);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        dp_if.coef_valid = 1'b1;
        repeat (10) tick();
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_outs", int'({dp_if.blk_valid, dp_if.blk_comp, dp_if.blk_idx, dc_pred_clr,
                               rst_marker, rst_num, busy, done, err}), 0);
        dp_if.coef_valid = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        chk("arst_after", int'({dp_if.blk_valid, busy, done}), 0);
        chk("arst_sb_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
